// File: rtl/race_sample_sequencer.sv
// race_sample_sequencer: FIFO-buffered complex sample feeder for the RACE adaptive filter.
// Issues one sample per FRAME_LEN-cycle frame and holds it stable for the whole frame.
module race_sample_sequencer #(
    parameter int SAMPLE_SIZE = 16,
    parameter int L = 7,
    parameter int FRAME_LEN = 2*L+4,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [SAMPLE_SIZE-1:0]       s_real,
    input  logic [SAMPLE_SIZE-1:0]       s_imag,
    output logic                         strobe_resync,
    output logic                         valid_in,
    output logic [SAMPLE_SIZE-1:0]       out_real,
    output logic [SAMPLE_SIZE-1:0]       out_imag,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN-1);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t                    state;
    logic [2*SAMPLE_SIZE-1:0]  mem [DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [CW-1:0]             cnt;
    logic                      full, empty, push, pop;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign s_ready = !rst && !full;
    assign push    = s_valid && s_ready && !flush;
    // A new sample is taken when idle or on the last cycle of a frame (back-to-back)
    assign pop     = !flush && !empty && (state == IDLE || cnt == LAST);
    assign busy    = state == FRAME;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_real, s_imag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            strobe_resync <= 1'b0;
            valid_in      <= 1'b0;
            out_real      <= '0;
            out_imag      <= '0;
        end else if (flush) begin
            state         <= IDLE;
            cnt           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            strobe_resync <= 1'b0;
            valid_in      <= 1'b0;
            out_real      <= '0;
            out_imag      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr               <= rd_ptr + AW'(1);
                {out_real, out_imag} <= mem[rd_ptr];
            end
            level         <= level + LW'(push) - LW'(pop);
            strobe_resync <= pop;
            valid_in      <= strobe_resync;
            cnt           <= (pop || cnt == LAST) ? '0 : (state == FRAME ? cnt + CW'(1) : cnt);
            state         <= (pop || (state == FRAME && cnt != LAST)) ? FRAME : IDLE;
        end
    end
endmodule

// File: tb/tb_race_sample_sequencer.sv
// tb_race_sample_sequencer: directed bench with a queue-based frame model checked every cycle.
module tb_race_sample_sequencer;
    localparam int SW = 16;
    localparam int FRAME_LEN = 18;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic s_valid = 1'b0;
    logic [SW-1:0] s_real = '0;
    logic [SW-1:0] s_imag = '0;
    logic s_ready, strobe_resync, valid_in, busy;
    logic [SW-1:0] out_real, out_imag;
    logic [$clog2(DEPTH+1)-1:0] level;

    race_sample_sequencer #(.SAMPLE_SIZE(SW), .L(7), .FRAME_LEN(FRAME_LEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_imag(s_imag), .strobe_resync(strobe_resync), .valid_in(valid_in),
        .out_real(out_real), .out_imag(out_imag), .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    int pass = 0;
    int total = 0;
    int cyc = 0;
    int stalls = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc++;

    // Model: queue of waiting samples plus the age of the current frame (-1 when idle)
    logic [31:0] q[$];
    int age = -1;
    logic [SW-1:0] m_real = '0;
    logic [SW-1:0] m_imag = '0;
    bit take, acc;

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            q.delete();
            age = -1;
            m_real = '0;
            m_imag = '0;
        end else begin
            take = q.size() > 0 && (age < 0 || age == FRAME_LEN-1);
            acc = s_valid && q.size() < DEPTH;
            if (take) begin
                {m_real, m_imag} = q.pop_front();
                age = 0;
            end else if (age >= 0) age = (age == FRAME_LEN-1) ? -1 : age + 1;
            if (acc) q.push_back({s_real, s_imag});
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cmp_strobe", strobe_resync, age == 0);
        chk("cmp_valid_in", valid_in, age == 1);
        chk("cmp_busy", busy, age >= 0);
        chk("cmp_out_real", out_real, m_real);
        chk("cmp_out_imag", out_imag, m_imag);
        chk("cmp_level", level, q.size());
        chk("cmp_s_ready", s_ready, !rst && q.size() < DEPTH);
    end

    int st_cyc[$];
    logic [SW-1:0] st_val[$];
    always @(negedge clk) if (strobe_resync) begin
        st_cyc.push_back(cyc);
        st_val.push_back(out_real);
    end

    task automatic push(input logic [SW-1:0] r, input logic [SW-1:0] i);
        int n = 0;
        s_valid = 1'b1;
        s_real = r;
        s_imag = i;
        while (!s_ready && n < 200) begin
            chk("bp_level_full", level, DEPTH);
            stalls++;
            @(negedge clk);
            n++;
        end
        chk("push_timeout", n < 200, 1);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || level != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < 2000, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_log();
        st_cyc.delete();
        st_val.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int t0, t1;
    initial begin
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_out_real", out_real, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", strobe_resync, 0);
        chk("rst_ready_after", s_ready, 1);

        // Single sample latency and frame length
        t0 = cyc;
        s_valid = 1'b1; s_real = 16'h1234; s_imag = 16'hFEDC;
        @(negedge clk);
        s_valid = 1'b0;
        chk("t1_level", level, 1);
        @(negedge clk);
        chk("t1_strobe", strobe_resync, 1);
        chk("t1_out_real", out_real, 16'h1234);
        chk("t1_out_imag", out_imag, 16'hFEDC);
        chk("t1_valid_early", valid_in, 0);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_valid_in", valid_in, 1);
        chk("t1_strobe_low", strobe_resync, 0);
        repeat (16) @(negedge clk);
        chk("t1_busy_last", busy, 1);
        @(negedge clk);
        chk("t1_busy_end", busy, 0);
        chk("t1_out_held", out_real, 16'h1234);
        chk("t1_cycle", cyc - t0, 20);

        // Back-to-back frames
        clear_log();
        t0 = cyc;
        push(16'h0011, 16'h1100);
        push(16'h0022, 16'h2200);
        push(16'h0033, 16'h3300);
        s_valid = 1'b0;
        wait_idle();
        chk("b2b_count", st_cyc.size(), 3);
        for (int k = 0; k < 3 && k < st_cyc.size(); k++) begin
            chk("b2b_strobe_cycle", st_cyc[k] - t0, 2 + 18*k);
            chk("b2b_value", st_val[k], 16'h0011 * (k + 1));
        end

        // Backpressure with six pushes into a depth-4 FIFO
        clear_log();
        stalls = 0;
        for (int k = 0; k < 6; k++) push(16'h00A0 + 16'(k), 16'h0B00 + 16'(k));
        s_valid = 1'b0;
        chk("bp_stalled", stalls > 0, 1);
        wait_idle();
        chk("bp_count", st_cyc.size(), 6);
        for (int k = 0; k < 6 && k < st_cyc.size(); k++) begin
            chk("bp_value", st_val[k], 16'h00A0 + 16'(k));
            if (k > 0) chk("bp_spacing", st_cyc[k] - st_cyc[k-1], 18);
        end

        // Flush mid-frame at cnt=5 with two samples waiting
        clear_log();
        t0 = cyc;
        push(16'h0001, 16'h0101);
        push(16'h0002, 16'h0202);
        push(16'h0003, 16'h0303);
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("fl_level_before", level, 2);
        chk("fl_busy_before", busy, 1);
        flush = 1'b1; s_valid = 1'b1; s_real = 16'hDEAD; s_imag = 16'hBEEF;
        @(negedge clk);
        flush = 1'b0; s_valid = 1'b0;
        chk("fl_level", level, 0);
        chk("fl_busy", busy, 0);
        chk("fl_out_real", out_real, 0);
        chk("fl_out_imag", out_imag, 0);
        @(negedge clk);
        t1 = cyc;
        push(16'h0055, 16'h0066);
        s_valid = 1'b0;
        wait_idle();
        chk("fl_count", st_cyc.size(), 2);
        if (st_cyc.size() == 2) begin
            chk("fl_first_value", st_val[0], 16'h0001);
            chk("fl_restart_value", st_val[1], 16'h0055);
            chk("fl_restart_latency", st_cyc[1] - t1, 2);
        end

        // Asynchronous reset while valid_in is high
        push(16'h0077, 16'h0088);
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ar_valid_before", valid_in, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid_in", valid_in, 0);
        chk("ar_strobe", strobe_resync, 0);
        chk("ar_busy", busy, 0);
        chk("ar_out_real", out_real, 0);
        chk("ar_out_imag", out_imag, 0);
        chk("ar_s_ready", s_ready, 0);
        @(negedge clk);
        chk("ar_s_ready_hold", s_ready, 0);
        rst = 1'b0;
        #1;
        chk("ar_s_ready_after", s_ready, 1);
        chk("ar_level_after", level, 0);
        repeat (5) @(negedge clk);

        // Pointer wrap: 20 samples with random gaps
        clear_log();
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            push(16'(i), 16'h0100 + 16'(i));
        end
        s_valid = 1'b0;
        wait_idle();
        chk("wr_count", st_cyc.size(), 20);
        for (int k = 0; k < 20 && k < st_cyc.size(); k++) begin
            chk("wr_value", st_val[k], 16'(k));
            if (k > 0) chk("wr_spacing", st_cyc[k] - st_cyc[k-1] >= 18, 1);
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
